// File: rtl/cam_sequencer.sv
// Parametrised motor-driven cam switch: a ms-stepped shaft position drives N_CH
// contacts, each with a programmable closed window, inversion and wrap-around.

module cam_contact #(
    parameter int               POS_W   = 4,
    parameter logic [POS_W-1:0] START   = '0,
    parameter logic [POS_W-1:0] END_POS = '0,
    parameter bit               INVERT  = 1'b0
) (
    input  logic [POS_W-1:0] position,
    output logic             raw,
    output logic             contact
);

    always_comb begin
        raw = 1'b0;
        if (START < END_POS)
            raw = (position >= START) && (position < END_POS);
        else if (START > END_POS)
            raw = (position >= START) || (position < END_POS);
    end

    assign contact = raw ^ INVERT;

endmodule

module cam_sequencer #(
    parameter int  PERIOD_MS = 9996,
    parameter int  N_CH      = 12,
    localparam int POS_W     = $clog2(PERIOD_MS),
    parameter logic [N_CH*POS_W-1:0] CH_START    = '0,
    parameter logic [N_CH*POS_W-1:0] CH_END      = '0,
    parameter logic [N_CH-1:0]       CH_INVERT   = '0,
    parameter logic [N_CH-1:0]       NOWAIT_MASK = '0,
    parameter bit                    ONESHOT     = 1'b0
) (
    input  logic             CLOCK,
    input  logic             rst,
    input  logic             tick_ms,
    input  logic             run,
    input  logic             stop,
    input  logic             hold,
    input  logic             home_req,
    output logic [N_CH-1:0]  contacts,
    output logic [POS_W-1:0] position,
    output logic             at_home,
    output logic             running,
    output logic             rev_done
);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(PERIOD_MS - 1);

    logic [N_CH-1:0] raw;
    logic            bypass;
    logic            done;

    // One comparator lane per contact; window bounds are fixed at elaboration.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        if (int'(CH_START[i*POS_W +: POS_W]) >= PERIOD_MS ||
            int'(CH_END[i*POS_W +: POS_W]) >= PERIOD_MS) begin : g_bad
            $error("cam_sequencer: channel window bound >= PERIOD_MS");
        end
        cam_contact #(
            .POS_W  (POS_W),
            .START  (CH_START[i*POS_W +: POS_W]),
            .END_POS(CH_END[i*POS_W +: POS_W]),
            .INVERT (CH_INVERT[i])
        ) u_contact (
            .position(position),
            .raw     (raw[i]),
            .contact (contacts[i])
        );
    end

    assign bypass  = |(raw & NOWAIT_MASK);
    assign running = run & ~stop & (~hold | bypass) & ~done;
    assign at_home = (position == '0);

    // done latches a completed one-shot revolution until run drops or homing.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            position <= '0;
            done     <= 1'b0;
            rev_done <= 1'b0;
        end else begin
            rev_done <= 1'b0;
            if (home_req) begin
                position <= '0;
                done     <= 1'b0;
            end else begin
                if (!run)
                    done <= 1'b0;
                if (tick_ms && running) begin
                    if (position == LAST_POS) begin
                        position <= '0;
                        rev_done <= 1'b1;
                        done     <= ONESHOT;
                    end else begin
                        position <= position + POS_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_sequencer.sv
// Randomised and directed checks of cam_sequencer (free-running and one-shot
// instances share stimulus) against a window/arithmetic reference model.

module tb_cam_sequencer;

    localparam int P = 12;

    logic CLOCK = 1'b0;
    logic rst = 1'b0, tick_ms = 1'b0, run = 1'b0, stop = 1'b0, hold = 1'b0, home_req = 1'b0;
    logic [2:0] ct [2];
    logic [3:0] ps [2];
    logic       ah [2];
    logic       rn_o [2];
    logic       rd [2];

    int nvec = 0, nerr = 0;
    int  m_pos [2];
    bit  m_done [2];
    bit  m_rev [2];
    bit  obs_run [2];
    bit  exp_run [2];

    always #5 CLOCK = ~CLOCK;

    cam_sequencer #(.PERIOD_MS(P), .N_CH(3), .CH_START({4'd9, 4'd4, 4'd1}),
        .CH_END({4'd2, 4'd6, 4'd3}), .CH_INVERT(3'b010), .NOWAIT_MASK(3'b100),
        .ONESHOT(1'b0)) dut (
        .CLOCK(CLOCK), .rst(rst), .tick_ms(tick_ms), .run(run), .stop(stop),
        .hold(hold), .home_req(home_req), .contacts(ct[0]), .position(ps[0]),
        .at_home(ah[0]), .running(rn_o[0]), .rev_done(rd[0]));

    cam_sequencer #(.PERIOD_MS(P), .N_CH(3), .CH_START({4'd9, 4'd4, 4'd1}),
        .CH_END({4'd2, 4'd6, 4'd3}), .CH_INVERT(3'b010), .NOWAIT_MASK(3'b100),
        .ONESHOT(1'b1)) dut_os (
        .CLOCK(CLOCK), .rst(rst), .tick_ms(tick_ms), .run(run), .stop(stop),
        .hold(hold), .home_req(home_req), .contacts(ct[1]), .position(ps[1]),
        .at_home(ah[1]), .running(rn_o[1]), .rev_done(rd[1]));

    // Window membership as modular distance from the start point.
    function automatic bit win(int s, int e, int p);
        if (s == e) return 1'b0;
        return ((p - s + P) % P) < ((e - s + P) % P);
    endfunction

    function automatic logic [2:0] exp_ct(int p);
        return {win(9, 2, p), win(4, 6, p), win(1, 3, p)} ^ 3'b010;
    endfunction

    function automatic bit exp_running(int k);
        return run && !stop && (!hold || win(9, 2, m_pos[k])) && !m_done[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pos[k] = 0; m_done[k] = 1'b0; m_rev[k] = 1'b0;
        end
    endtask

    task automatic cyc(input bit tk, input bit rn, input bit sp, input bit hd, input bit hr);
        @(negedge CLOCK);
        tick_ms = tk; run = rn; stop = sp; hold = hd; home_req = hr;
        #1;
        for (int k = 0; k < 2; k++) begin
            obs_run[k] = rn_o[k];
            exp_run[k] = exp_running(k);
        end
        @(posedge CLOCK);
        for (int k = 0; k < 2; k++) begin
            m_rev[k] = 1'b0;
            if (hr) begin
                m_pos[k] = 0; m_done[k] = 1'b0;
            end else begin
                if (!rn) m_done[k] = 1'b0;
                if (tk && exp_run[k]) begin
                    if (m_pos[k] == P - 1) begin
                        m_pos[k] = 0; m_rev[k] = 1'b1; m_done[k] = (k == 1);
                    end else begin
                        m_pos[k] = m_pos[k] + 1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        rst = 1'b1; tick_ms = 1'b0; run = 1'b0; stop = 1'b0; hold = 1'b0; home_req = 1'b0;
        model_reset();
        @(posedge CLOCK); #1;
        @(negedge CLOCK);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLOCK);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            nvec++; if (ps[k] !== 4'd0) begin nerr++; $display("FAIL reset_pos[%0d] got %0d exp 0", k, ps[k]); end
            nvec++; if (ct[k] !== 3'b110) begin nerr++; $display("FAIL reset_contacts[%0d] got %b exp 110", k, ct[k]); end
            nvec++; if (ah[k] !== 1'b1) begin nerr++; $display("FAIL reset_at_home[%0d] got %b exp 1", k, ah[k]); end
            nvec++; if (rd[k] !== 1'b0) begin nerr++; $display("FAIL reset_rev_done[%0d] got %b exp 0", k, rd[k]); end
        end
        do_reset();
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 1; i <= P; i++) begin
            cyc(1, 1, 0, 0, 0);
            nvec++; if (ps[0] !== 4'(i % P)) begin nerr++; $display("FAIL free_pos got %0d exp %0d", ps[0], i % P); end
            nvec++; if (ct[0] !== exp_ct(i % P)) begin nerr++; $display("FAIL free_contacts pos %0d got %b exp %b", i % P, ct[0], exp_ct(i % P)); end
            nvec++; if (rd[0] !== (i == P)) begin nerr++; $display("FAIL free_rev_done tick %0d got %b exp %b", i, rd[0], i == P); end
        end
        cyc(0, 1, 0, 0, 0);
        nvec++; if (rd[0] !== 1'b0) begin nerr++; $display("FAIL free_rev_pulse_width got %b exp 0", rd[0]); end
    endtask

    task automatic test_hold_bypass();
        int exp_seq [7] = '{10, 11, 0, 1, 2, 2, 2};
        do_reset();
        repeat (3) cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 1, 0);
            nvec++; if (ps[0] !== 4'd3) begin nerr++; $display("FAIL hold_stall got %0d exp 3", ps[0]); end
            nvec++; if (obs_run[0] !== 1'b0) begin nerr++; $display("FAIL hold_running got %b exp 0", obs_run[0]); end
        end
        cyc(0, 1, 0, 0, 1);
        nvec++; if (ps[0] !== 4'd0) begin nerr++; $display("FAIL hold_home got %0d exp 0", ps[0]); end
        repeat (9) cyc(1, 1, 0, 0, 0);
        nvec++; if (ps[0] !== 4'd9) begin nerr++; $display("FAIL hold_reach9 got %0d exp 9", ps[0]); end
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1, 0, 1, 0);
            nvec++; if (ps[0] !== 4'(exp_seq[i])) begin nerr++; $display("FAIL bypass_seq step %0d got %0d exp %0d", i, ps[0], exp_seq[i]); end
        end
    endtask

    task automatic test_stop();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 1, 0, 0);
            nvec++; if (ps[0] !== 4'd0) begin nerr++; $display("FAIL stop_pos got %0d exp 0", ps[0]); end
            nvec++; if (obs_run[0] !== 1'b0) begin nerr++; $display("FAIL stop_running got %b exp 0", obs_run[0]); end
        end
        cyc(1, 1, 0, 0, 0);
        nvec++; if (ps[0] !== 4'd1) begin nerr++; $display("FAIL stop_release got %0d exp 1", ps[0]); end
    endtask

    task automatic test_oneshot();
        do_reset();
        repeat (P) cyc(1, 1, 0, 0, 0);
        nvec++; if (ps[1] !== 4'd0) begin nerr++; $display("FAIL os_wrap_pos got %0d exp 0", ps[1]); end
        nvec++; if (rd[1] !== 1'b1) begin nerr++; $display("FAIL os_rev_done got %b exp 1", rd[1]); end
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 0, 0);
            nvec++; if (ps[1] !== 4'd0 || ah[1] !== 1'b1) begin nerr++; $display("FAIL os_halt got pos %0d home %b exp 0/1", ps[1], ah[1]); end
            nvec++; if (obs_run[1] !== 1'b0) begin nerr++; $display("FAIL os_running got %b exp 0", obs_run[1]); end
        end
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        nvec++; if (ps[1] !== 4'd1) begin nerr++; $display("FAIL os_rearm got %0d exp 1", ps[1]); end
    endtask

    task automatic test_home_vs_tick();
        do_reset();
        repeat (7) cyc(1, 1, 0, 0, 0);
        nvec++; if (ps[0] !== 4'd7) begin nerr++; $display("FAIL home_pre got %0d exp 7", ps[0]); end
        cyc(1, 1, 0, 0, 1);
        nvec++; if (ps[0] !== 4'd0 || rd[0] !== 1'b0) begin nerr++; $display("FAIL home_tick got pos %0d rev %b exp 0/0", ps[0], rd[0]); end
        repeat (P - 1) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 1);
        nvec++; if (ps[0] !== 4'd0 || rd[0] !== 1'b0) begin nerr++; $display("FAIL home_at_last got pos %0d rev %b exp 0/0", ps[0], rd[0]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (5) cyc(1, 1, 0, 0, 0);
        @(negedge CLOCK);
        tick_ms = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        nvec++; if (ps[0] !== 4'd0) begin nerr++; $display("FAIL async_pos got %0d exp 0", ps[0]); end
        nvec++; if (ct[0] !== 3'b110) begin nerr++; $display("FAIL async_contacts got %b exp 110", ct[0]); end
        nvec++; if (rd[0] !== 1'b0) begin nerr++; $display("FAIL async_rev got %b exp 0", rd[0]); end
        @(negedge CLOCK);
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 4) != 0, ($urandom % 10) != 0, ($urandom % 8) == 0,
                ($urandom % 3) == 0, ($urandom % 60) == 0);
            for (int k = 0; k < 2; k++) begin
                nvec++; if (ps[k] !== 4'(m_pos[k])) begin nerr++; $display("FAIL rnd_pos[%0d] cyc %0d got %0d exp %0d", k, i, ps[k], m_pos[k]); end
                nvec++; if (ct[k] !== exp_ct(m_pos[k])) begin nerr++; $display("FAIL rnd_contacts[%0d] cyc %0d got %b exp %b", k, i, ct[k], exp_ct(m_pos[k])); end
                nvec++; if (rd[k] !== m_rev[k] || ah[k] !== (m_pos[k] == 0)) begin nerr++; $display("FAIL rnd_status[%0d] cyc %0d got rev %b home %b exp %b %b", k, i, rd[k], ah[k], m_rev[k], m_pos[k] == 0); end
                nvec++; if (obs_run[k] !== exp_run[k]) begin nerr++; $display("FAIL rnd_running[%0d] cyc %0d got %b exp %b", k, i, obs_run[k], exp_run[k]); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_free_run();
        test_hold_bypass();
        test_stop();
        test_oneshot();
        test_home_vs_tick();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/cam_sequencer.md
Name: cam_sequencer

Overview:
- Generic, parametrised model of a motor-driven multi-section wafer/cam switch for G-15 power and turn-on sequencing.
- A millisecond-stepped shaft position counter drives N_CH contact outputs. Each contact has a programmable closed window, optional inversion and optional wrap-around.
- Adds capabilities the fixed turn-on timer lacks: hold-bypass windows selected per channel, one-shot (single revolution) mode, synchronous homing, and revolution/status outputs.
- Instantiated by turn-on and other timed-sequence logic in place of hand-coded comparator chains.

Parameters:
- PERIOD_MS, 9996, shaft revolution length in ticks; position wraps at PERIOD_MS-1. Must be >= 2.
- N_CH, 12, number of contact channels.
- POS_W, $clog2(PERIOD_MS), position width (derived localparam, not overridable).
- CH_START, all zero, N_CH*POS_W packed; channel i closes at position CH_START[i].
- CH_END, all zero, N_CH*POS_W packed; channel i opens at position CH_END[i] (exclusive).
- CH_INVERT, '0, N_CH mask; 1 means the contact is normally closed (output inverted).
- NOWAIT_MASK, '0, N_CH mask; the motor ignores hold while any masked channel's raw window is active.
- ONESHOT, 0, when set to 1 the shaft stops at home after one full revolution.

Ports:
- CLOCK, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- tick_ms, input, 1, one-CLOCK pulse per millisecond.
- run, input, 1, motor drive request (level).
- stop, input, 1, motor inhibit (level); overrides run.
- hold, input, 1, external wait (e.g. tape); stalls the motor outside no-wait windows.
- home_req, input, 1, synchronous return to position 0.
- contacts, output, N_CH, contact states.
- position, output, POS_W, shaft position in ms.
- at_home, output, 1, position == 0.
- running, output, 1, advance enable for the current cycle.
- rev_done, output, 1, one-CLOCK pulse on wrap.

Behaviour:
- Reset (asynchronous, rst=1): position=0, done=0, rev_done=0. Contacts then equal the combinational value for position 0. at_home=1.
- raw[i]:
  - START<END: START <= position < END.
  - START>END (wraps): position >= START or position < END.
  - START==END: never active.
- contacts[i] = raw[i] XOR CH_INVERT[i]. Combinational from the registered position, so it has zero latency relative to position.
- bypass = |(raw & NOWAIT_MASK).
- running = run & ~stop & (~hold | bypass) & ~done. Combinational.
- Per-CLOCK priority:
  1. home_req: position<=0, done<=0, no rev_done pulse.
  2. Otherwise, tick_ms & running: position advances by 1. At PERIOD_MS-1 it wraps to 0, rev_done<=1 for the next cycle, and done<=ONESHOT.
  3. Otherwise position holds. rev_done is 0 in every cycle not immediately following a wrap.
- done clears on home_req or when run=0 for any cycle. ONESHOT re-arms by dropping run.
- Increment width is POS_W. Position never reaches PERIOD_MS.
- stop, hold and run are sampled only in tick_ms cycles for advancing. Changes between ticks have no effect on position.
- Reset mid-revolution: immediate return to 0. No rev_done pulse.
- Parameter check: CH_START/CH_END values >= PERIOD_MS are illegal; simulation asserts at elaboration.

Test Plan:
All scenarios use PERIOD_MS=12, N_CH=3, CH_START={9,4,1}, CH_END={2,6,3}, CH_INVERT=3'b010, NOWAIT_MASK=3'b100.
- Free run: run=1 and 12 ticks from reset -> position 0,1..11,0. contacts[0]=1 at pos 1-2. contacts[1]=0 at pos 4-5, else 1. contacts[2]=1 at pos 9,10,11,0,1. rev_done is a single pulse after the 11->0 tick.
- Hold bypass: hold=1 from pos 3 -> stuck at 3 over 5 ticks. Then home_req and tick to pos 9 with hold=0, set hold=1 -> advances 9,10,11,0,1, stalls at 2.
- Stop priority: run=1, stop=1 for 10 ticks -> position stays 0 and running=0. Release stop -> advances on the next tick.
- One-shot (ONESHOT=1): 12 ticks -> wraps to 0 and halts, at_home=1, running=0 over a further 5 ticks. Drop run for 1 cycle and reassert -> advances again.
- Home vs tick: at pos 7, home_req and tick_ms in the same cycle -> position=0, rev_done=0.
- Async reset: assert rst mid-cycle at pos 5 -> position=0 immediately, without waiting for a CLOCK edge; contacts show the pos-0 pattern 3'b110.
